// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator with horizontal/vertical phase FSMs and registered sync/blank outputs
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pixel_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  typedef enum logic [1:0] {H_VIS, H_FRONT, H_SYNCP, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_VIS, V_FRONT, V_SYNCP, V_BACK} v_state_t;
  h_state_t   h_state, h_next;
  v_state_t   v_state, v_next;
  logic       x_wrap, y_wrap;
  logic [9:0] x_next, y_next;
  always_comb begin
    x_wrap = pixel_en && x == H_LAST;
    y_wrap = x_wrap && y == V_LAST;
    x_next = !pixel_en ? x : x_wrap ? '0 : x + 10'd1;
    y_next = !x_wrap ? y : y_wrap ? '0 : y + 10'd1;
    h_next = h_state;
    if (pixel_en)
      case (h_state)
        H_VIS:   h_next = x == H_VIS_END  ? H_FRONT : H_VIS;
        H_FRONT: h_next = x == H_FP_END   ? H_SYNCP : H_FRONT;
        H_SYNCP: h_next = x == H_SYNC_END ? H_BACK  : H_SYNCP;
        H_BACK:  h_next = x == H_LAST     ? H_VIS   : H_BACK;
      endcase
    v_next = v_state;
    if (x_wrap)
      case (v_state)
        V_VIS:   v_next = y == V_VIS_END  ? V_FRONT : V_VIS;
        V_FRONT: v_next = y == V_FP_END   ? V_SYNCP : V_FRONT;
        V_SYNCP: v_next = y == V_SYNC_END ? V_BACK  : V_SYNCP;
        V_BACK:  v_next = y == V_LAST     ? V_VIS   : V_BACK;
      endcase
  end
  // outputs are decoded from the next state so they line up with the registered x/y
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x           <= '0;
      y           <= '0;
      h_state     <= H_VIS;
      v_state     <= V_VIS;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= x_next;
      y           <= y_next;
      h_state     <= h_next;
      v_state     <= v_next;
      hsync       <= h_next != H_SYNCP;
      vsync       <= v_next != V_SYNCP;
      video_on    <= h_next == H_VIS && v_next == V_VIS;
      line_start  <= x_wrap;
      frame_start <= y_wrap;
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench comparing a default and a tiny-timing instance against an arithmetic pixel-count model
module tb_vga_sync_gen;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic pixel_en = 1'b0;
  logic hs_d, vs_d, vo_d, ls_d, fs_d, hs_s, vs_s, vo_s, ls_s, fs_s;
  logic [9:0] x_d, y_d, x_s, y_s;
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vo;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } o_t;
  typedef struct packed {
    o_t d;
    o_t s;
  } exp_t;
  localparam o_t RST = '{hs: 1'b1, vs: 1'b1, vo: 1'b1, x: 10'd0, y: 10'd0, ls: 1'b0, fs: 1'b0};
  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   t = 0;

  always #5 clock = ~clock;

  vga_sync_gen dut_d (
    .clock(clock), .reset(reset), .pixel_en(pixel_en),
    .hsync(hs_d), .vsync(vs_d), .video_on(vo_d), .x(x_d), .y(y_d),
    .line_start(ls_d), .frame_start(fs_d)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_s (
    .clock(clock), .reset(reset), .pixel_en(pixel_en),
    .hsync(hs_s), .vsync(vs_s), .video_on(vo_s), .x(x_s), .y(y_s),
    .line_start(ls_s), .frame_start(fs_s)
  );

  // tk pixel ticks since reset fully determine the raster position
  function automatic o_t model(input int tk, input int ha, input int hf, input int hsw, input int hb,
                               input int va, input int vf, input int vsw, input int vb, input logic tick);
    int ht, vt, px, py;
    o_t o;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    px = tk % ht;
    py = (tk / ht) % vt;
    o.x  = 10'(px);
    o.y  = 10'(py);
    o.hs = !(px >= ha + hf && px < ha + hf + hsw);
    o.vs = !(py >= va + vf && py < va + vf + vsw);
    o.vo = px < ha && py < va;
    o.ls = tick && px == 0;
    o.fs = tick && px == 0 && py == 0;
    return o;
  endfunction

  function automatic o_t small_model(input int tk, input logic tick);
    return model(tk, 8, 2, 3, 1, 4, 1, 1, 1, tick);
  endfunction

  task automatic step(input logic r, input logic e);
    exp_t ex;
    logic tick;
    @(negedge clock);
    reset = r;
    pixel_en = e;
    if (!r) t = 0;
    else if (e) t++;
    tick = r && e;
    ex.d = model(t, 640, 16, 96, 48, 480, 10, 2, 33, tick);
    ex.s = small_model(t, tick);
    q.push_back(ex);
  endtask

  task automatic check(input string name, input o_t got, input o_t want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s @%0t got hs=%b vs=%b vo=%b x=%0d y=%0d ls=%b fs=%b want hs=%b vs=%b vo=%b x=%0d y=%0d ls=%b fs=%b",
                  name, $time, got.hs, got.vs, got.vo, got.x, got.y, got.ls, got.fs,
                  want.hs, want.vs, want.vo, want.x, want.y, want.ls, want.fs);
  endtask

  initial forever begin
    @(posedge clock);
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("dflt_out", {hs_d, vs_d, vo_d, x_d, y_d, ls_d, fs_d}, mon_e.d);
      check("small_out", {hs_s, vs_s, vo_s, x_s, y_s, ls_s, fs_s}, mon_e.s);
    end
  end

  initial begin
    int n;
    o_t m;
    repeat (3) step(1'b0, 1'b0);
    repeat (1700) step(1'b1, 1'b1);
    for (int i = 0; i < 6400; i++) step(1'b1, i % 4 == 3);
    repeat (20000) step(1'b1, 1'($urandom_range(0, 1)));
    n = 0;
    m = small_model(t, 1'b0);
    while (!(!m.hs && !m.vs) && n < 2000) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      m = small_model(t, 1'b0);
      n++;
    end
    if (n == 2000) begin
      checks++;
      $display("FAIL rst_wait no sync window reached within %0d steps (required < 2000)", n);
    end else begin
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check("async_rst_dflt", {hs_d, vs_d, vo_d, x_d, y_d, ls_d, fs_d}, RST);
      check("async_rst_small", {hs_s, vs_s, vo_s, x_s, y_s, ls_s, fs_s}, RST);
    end
    repeat (4) step(1'b0, 1'b1);
    repeat (300) step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    repeat (2) @(posedge clock);
    #2;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL queue_drain got %0d pending want 0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
